// File: rtl/proc_fetch.sv
// Instruction-fetch datapath: owns the PC and IR and turns control strobes into
// a req/gnt/rvalid read on the instruction-memory port.
module proc_fetch #(
  parameter int              XLEN     = 32,
  parameter int              ISA_DPTH = 64,
  parameter logic [XLEN-1:0] RST_PC   = '0,
  localparam int             OPW      = $clog2(ISA_DPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_ir_e,
  input  logic            i_pc_e,
  input  logic            i_pc_sel,
  input  logic [XLEN-1:0] i_pc_tgt,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_ir,
  output logic [OPW-1:0]  o_opcd,
  output logic            o_ir_vld,
  output logic            o_busy
);

  // state  | meaning
  // S_IDLE | no fetch in flight, waiting for i_ir_e
  // S_REQ  | request asserted, waiting for grant
  // S_WAIT | granted, waiting for read data
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_ir;
  logic [XLEN-1:0] r_addr;
  logic            r_ir_vld;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pc     <= RST_PC;
      r_ir     <= '0;
      r_addr   <= '0;
      r_ir_vld <= 1'b0;
    end else begin
      // PC update runs regardless of fetch state; a fetch started on the same
      // edge latches the pre-update PC into r_addr.
      if (i_pc_e) begin
        if (i_pc_sel) r_pc <= {i_pc_tgt[XLEN-1:2], 2'b00};
        else          r_pc <= r_pc + XLEN'(4);
      end

      case (r_state)
        S_IDLE: begin
          if (i_ir_e) begin
            r_addr   <= r_pc;
            r_ir_vld <= 1'b0;
            r_state  <= S_REQ;
          end
        end
        S_REQ: begin
          if (i_imem_gnt) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_imem_rvalid) begin
            r_ir     <= i_imem_rdata;
            r_ir_vld <= 1'b1;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_imem_req  = (r_state == S_REQ);
  assign o_busy      = (r_state != S_IDLE);
  assign o_imem_addr = r_addr;
  assign o_pc        = r_pc;
  assign o_ir        = r_ir;
  assign o_ir_vld    = r_ir_vld;
  assign o_opcd      = r_ir[XLEN-1 -: OPW];

endmodule

// File: tb/tb_proc_fetch.sv
// Directed self-checking bench for proc_fetch: reset, basic fetch, stalls,
// redirect, PC wrap and reset during an in-flight fetch.
module tb_proc_fetch;

  localparam int XLEN = 32;
  localparam int OPW  = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            i_ir_e, i_pc_e, i_pc_sel;
  logic [XLEN-1:0] i_pc_tgt;
  logic            o_imem_req;
  logic [XLEN-1:0] o_imem_addr;
  logic            i_imem_gnt, i_imem_rvalid;
  logic [XLEN-1:0] i_imem_rdata;
  logic [XLEN-1:0] o_pc, o_ir;
  logic [OPW-1:0]  o_opcd;
  logic            o_ir_vld, o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  proc_fetch #(.XLEN(XLEN), .ISA_DPTH(64), .RST_PC(32'h0000_0100)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_ir_e(i_ir_e), .i_pc_e(i_pc_e), .i_pc_sel(i_pc_sel), .i_pc_tgt(i_pc_tgt),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_gnt(i_imem_gnt), .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .o_pc(o_pc), .o_ir(o_ir), .o_opcd(o_opcd), .o_ir_vld(o_ir_vld), .o_busy(o_busy)
  );

  // Advance one active edge; inputs are then driven and outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_ir_e = 0; i_pc_e = 0; i_pc_sel = 0; i_pc_tgt = '0;
    i_imem_gnt = 0; i_imem_rvalid = 0; i_imem_rdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    tick();
    n_checks++; if (o_pc !== 32'h100) begin n_fail++; $display("FAIL reset_pc got %h exp %h", o_pc, 32'h100); end
    n_checks++; if (o_ir_vld !== 1'b0) begin n_fail++; $display("FAIL reset_ir_vld got %b exp 0", o_ir_vld); end
    n_checks++; if (o_imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", o_imem_req); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", o_busy); end
    n_checks++; if (o_ir !== 32'h0) begin n_fail++; $display("FAIL reset_ir got %h exp 0", o_ir); end
    n_checks++; if (o_imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", o_imem_addr); end
  endtask

  task automatic test_basic_fetch();
    i_ir_e = 1; i_pc_e = 1; i_pc_sel = 0;
    tick();
    i_ir_e = 0; i_pc_e = 0;
    n_checks++; if (o_imem_req !== 1'b1) begin n_fail++; $display("FAIL basic_req got %b exp 1", o_imem_req); end
    n_checks++; if (o_imem_addr !== 32'h100) begin n_fail++; $display("FAIL basic_addr got %h exp %h", o_imem_addr, 32'h100); end
    n_checks++; if (o_pc !== 32'h104) begin n_fail++; $display("FAIL basic_pc got %h exp %h", o_pc, 32'h104); end
    n_checks++; if (o_ir_vld !== 1'b0) begin n_fail++; $display("FAIL basic_vld_e1 got %b exp 0", o_ir_vld); end
    i_imem_gnt = 1;
    tick();
    i_imem_gnt = 0;
    n_checks++; if (o_imem_req !== 1'b0 || o_busy !== 1'b1) begin n_fail++; $display("FAIL basic_wait got req=%b busy=%b exp req=0 busy=1", o_imem_req, o_busy); end
    i_imem_rvalid = 1; i_imem_rdata = 32'h8C22_0004;
    tick();
    i_imem_rvalid = 0; i_imem_rdata = '0;
    n_checks++; if (o_ir !== 32'h8C22_0004) begin n_fail++; $display("FAIL basic_ir got %h exp %h", o_ir, 32'h8C22_0004); end
    n_checks++; if (o_opcd !== 6'b100011) begin n_fail++; $display("FAIL basic_opcd got %b exp 100011", o_opcd); end
    n_checks++; if (o_ir_vld !== 1'b1) begin n_fail++; $display("FAIL basic_vld got %b exp 1", o_ir_vld); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy got %b exp 0", o_busy); end
    tick();
    n_checks++; if (o_ir !== 32'h8C22_0004 || o_ir_vld !== 1'b1) begin n_fail++; $display("FAIL basic_hold got ir=%h vld=%b exp ir=8c220004 vld=1", o_ir, o_ir_vld); end
  endtask

  task automatic test_stall_redirect();
    i_ir_e = 1;
    i_imem_rvalid = 1; i_imem_rdata = 32'hBAD0_BAD0;  // rvalid in IDLE must be ignored
    tick();
    i_ir_e = 0; i_imem_rvalid = 0;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h104) begin n_fail++; $display("FAIL stall_req_%0d got req=%b addr=%h exp req=1 addr=104", i, o_imem_req, o_imem_addr); end
      if (i == 1) i_imem_rvalid = 1;  // rvalid in REQ must be ignored too
      tick();
      i_imem_rvalid = 0;
    end
    n_checks++; if (o_ir !== 32'h8C22_0004 || o_ir_vld !== 1'b0) begin n_fail++; $display("FAIL stall_ir_hold got ir=%h vld=%b exp ir=8c220004 vld=0", o_ir, o_ir_vld); end
    i_imem_gnt = 1;
    tick();
    i_imem_gnt = 0;
    // first WAIT cycle: second fetch strobe plus a redirect
    i_ir_e = 1; i_pc_e = 1; i_pc_sel = 1; i_pc_tgt = 32'h0000_2007;
    tick();
    i_ir_e = 0; i_pc_e = 0; i_pc_sel = 0; i_pc_tgt = '0;
    n_checks++; if (o_pc !== 32'h2004) begin n_fail++; $display("FAIL redirect_pc got %h exp %h", o_pc, 32'h2004); end
    n_checks++; if (o_imem_addr !== 32'h104 || o_imem_req !== 1'b0 || o_busy !== 1'b1) begin n_fail++; $display("FAIL redirect_inflight got addr=%h req=%b busy=%b exp addr=104 req=0 busy=1", o_imem_addr, o_imem_req, o_busy); end
    tick();
    n_checks++; if (o_ir !== 32'h8C22_0004 || o_ir_vld !== 1'b0) begin n_fail++; $display("FAIL stall_wait_ir got ir=%h vld=%b exp ir=8c220004 vld=0", o_ir, o_ir_vld); end
    i_imem_rvalid = 1; i_imem_rdata = 32'h1234_5678;
    tick();
    i_imem_rvalid = 0; i_imem_rdata = '0;
    n_checks++; if (o_ir !== 32'h1234_5678 || o_opcd !== 6'b000100) begin n_fail++; $display("FAIL stall_ir got ir=%h opcd=%b exp ir=12345678 opcd=000100", o_ir, o_opcd); end
    n_checks++; if (o_ir_vld !== 1'b1 || o_busy !== 1'b0) begin n_fail++; $display("FAIL stall_done got vld=%b busy=%b exp vld=1 busy=0", o_ir_vld, o_busy); end
    tick();
    n_checks++; if (o_imem_req !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL stall_single_req got req=%b busy=%b exp req=0 busy=0", o_imem_req, o_busy); end
  endtask

  task automatic test_wrap();
    i_imem_gnt = 1;  // grant outside REQ is ignored
    i_pc_e = 1; i_pc_sel = 1; i_pc_tgt = 32'hFFFF_FFFF;
    tick();
    n_checks++; if (o_pc !== 32'hFFFF_FFFC || o_busy !== 1'b0) begin n_fail++; $display("FAIL wrap_set got pc=%h busy=%b exp pc=fffffffc busy=0", o_pc, o_busy); end
    i_pc_sel = 0; i_pc_tgt = '0;
    tick();
    i_pc_e = 0; i_imem_gnt = 0;
    n_checks++; if (o_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc got %h exp 0", o_pc); end
  endtask

  task automatic test_reset_mid_op();
    i_ir_e = 1;
    tick();
    i_ir_e = 0; i_imem_gnt = 1;
    tick();
    i_imem_gnt = 0;
    n_checks++; if (o_busy !== 1'b1 || o_imem_addr !== 32'h0) begin n_fail++; $display("FAIL rstmid_wait got busy=%b addr=%h exp busy=1 addr=0", o_busy, o_imem_addr); end
    rst_n = 0;
    tick();
    rst_n = 1;
    n_checks++; if (o_busy !== 1'b0 || o_ir !== 32'h0 || o_ir_vld !== 1'b0 || o_pc !== 32'h100) begin n_fail++; $display("FAIL rstmid_reset got busy=%b ir=%h vld=%b pc=%h exp busy=0 ir=0 vld=0 pc=100", o_busy, o_ir, o_ir_vld, o_pc); end
    tick();
    i_imem_rvalid = 1; i_imem_rdata = 32'hDEAD_BEEF;
    tick();
    i_imem_rvalid = 0; i_imem_rdata = '0;
    n_checks++; if (o_ir !== 32'h0 || o_ir_vld !== 1'b0 || o_busy !== 1'b0 || o_imem_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_late_rvalid got ir=%h vld=%b busy=%b req=%b exp all 0", o_ir, o_ir_vld, o_busy, o_imem_req); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_stall_redirect();
    test_wrap();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
